// File: rtl/dm_load_ctrl.sv
// -----------------------------------------------------------------------------
// dm_load_ctrl
//
// MEM-stage load controller in front of a synchronous-read data memory port.
// It accepts one load at a time, issues a single word read, then extracts the
// byte, halfword or word lane and sign- or zero-extends it. The result goes
// back over a second valid/ready handshake, with an error flag for illegal or
// out-of-range loads.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload stable until that edge. The
// consumer may assert ready at any time. Ready without valid does nothing.
//
// Optional feature (compile-time macro):
//   DM_LOAD_ALIGN_CHECK_EN - when defined, misaligned halfword/word loads
//                            fault. When undefined, the low address bits are
//                            ignored for halfword/word, which matches the
//                            store path's forced alignment.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   i_req_valid       load request present
//   o_req_ready       request can be accepted (IDLE only)
//   i_req_addr        byte address
//   i_req_type        01 byte, 10 halfword, 11 word, 00 illegal
//   i_req_unsigned    1 = zero-extend, 0 = sign-extend
//   i_req_pc          PC of the load, returned with the response
//   o_mem_rd_en       memory read strobe (one cycle per good load)
//   o_mem_addr        word index into the memory
//   i_mem_rdata       read data, valid the cycle after o_mem_rd_en
//   o_rsp_valid       response present
//   i_rsp_ready       consumer accepts the response
//   o_rsp_data        extended load data (0 on error)
//   o_rsp_err         load faulted
//   o_rsp_pc          PC of the responding load
//   o_dbg_state       current FSM state (0 IDLE, 1 READ, 2 RESP)
// -----------------------------------------------------------------------------
module dm_load_ctrl #(
    parameter int ADDR_WORDS_LOG2 = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [31:0]                i_req_addr,
    input  logic [1:0]                 i_req_type,
    input  logic                       i_req_unsigned,
    input  logic [31:0]                i_req_pc,
    output logic                       o_mem_rd_en,
    output logic [ADDR_WORDS_LOG2-1:0] o_mem_addr,
    input  logic [31:0]                i_mem_rdata,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [31:0]                o_rsp_data,
    output logic                       o_rsp_err,
    output logic [31:0]                o_rsp_pc,
    output logic [1:0]                 o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_BYTE = 2'b01;
    localparam logic [1:0] TYPE_HALF = 2'b10;
    localparam logic [1:0] TYPE_WORD = 2'b11;
    localparam logic [1:0] TYPE_ILL  = 2'b00;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_type_err;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_err;

    // One-entry request latch
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_type;
    logic        r_unsigned;
    logic [31:0] r_pc;

    // One-entry response register
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Request fault detection
    // ------------------------------------------------------------------
    assign w_type_err  = (i_req_type == TYPE_ILL);
    // Any address bit above the memory's byte range makes the load fault.
    assign w_range_err = |i_req_addr[31:ADDR_WORDS_LOG2+2];

`ifdef DM_LOAD_ALIGN_CHECK_EN
    assign w_align_err = ((i_req_type == TYPE_HALF) && i_req_addr[0]) ||
                         ((i_req_type == TYPE_WORD) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_align_err = 1'b0;
`endif

    assign w_err = w_type_err || w_range_err || w_align_err;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        o_req_ready = 1'b0;
        o_mem_rd_en = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                // Reset wins over a simultaneous request, so no strobe
                // escapes while reset is high.
                if (i_req_valid && !reset) begin
                    w_accept    = 1'b1;
                    o_mem_rd_en = !w_err;
                    w_next      = w_err ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The read index is driven only while a strobe is issued, so the port
    // idles at zero.
    assign o_mem_addr  = o_mem_rd_en ? i_req_addr[ADDR_WORDS_LOG2+1:2] : '0;
    assign o_dbg_state = r_state;

    // ------------------------------------------------------------------
    // Lane extraction from the returned word
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
    end

    assign w_half = r_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        w_load_data = i_mem_rdata;
        case (r_type)
            TYPE_BYTE: w_load_data = {{24{!r_unsigned && w_byte[7]}}, w_byte};
            TYPE_HALF: w_load_data = {{16{!r_unsigned && w_half[15]}}, w_half};
            default:   w_load_data = i_mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_lo  <= 2'b00;
            r_type     <= 2'b00;
            r_unsigned <= 1'b0;
            r_pc       <= 32'h0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr_lo  <= i_req_addr[1:0];
                r_type     <= i_req_type;
                r_unsigned <= i_req_unsigned;
                r_pc       <= i_req_pc;
                if (w_err) begin
                    r_rsp_data <= 32'h0;
                    r_rsp_err  <= 1'b1;
                end
            end
            // mem_rdata is valid during READ, one cycle after the strobe.
            if (r_state == ST_READ) begin
                r_rsp_data <= w_load_data;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign o_rsp_data = r_rsp_data;
    assign o_rsp_err  = r_rsp_err;
    assign o_rsp_pc   = r_pc;

endmodule

// File: doc/dm_load_ctrl.md
# dm_load_ctrl

Load-side controller for the data memory. It sits in the MEM stage between the pipeline and a synchronous-read data memory port. It accepts one load request at a time over a valid/ready handshake and issues a word read. It then extracts the byte, halfword or word lane and sign- or zero-extends it. The result is returned over a second valid/ready handshake, together with an error flag for illegal or out-of-range loads. It uses the same 2-bit access-type encoding and word-indexed addressing as the store path.

## Interface
- ADDR_WORDS_LOG2, 12, log2 of memory depth in words; mem_addr width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  load request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_addr  in  32  byte address
- req_type  in  2  01 byte, 10 halfword, 11 word, 00 illegal
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend (ignored for word)
- req_pc  in  32  PC of the load, carried to the response
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WORDS_LOG2  word index = req_addr[ADDR_WORDS_LOG2+1:2]
- mem_rdata  in  32  memory read data, valid the cycle after mem_rd_en
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  extended load data (0 on error)
- rsp_err  out  1  load faulted
- rsp_pc  out  32  PC of the responding load

## Operation
- FSM states: IDLE, READ, RESP.
- Reset state is IDLE. Reset values: req_ready=1, mem_rd_en=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_pc=0, mem_addr=0.
- **IDLE** on req_valid:
  - The request is accepted and addr, type, unsigned and pc are latched.
  - Error check:
    - req_type==00 → error.
    - req_addr[31:ADDR_WORDS_LOG2+2] ≠ 0 → error.
    - Misalignment → error (see Configuration).
  - On error: go to RESP with rsp_err=1, rsp_data=0. mem_rd_en stays 0.
  - Otherwise: mem_rd_en=1 combinationally in the accept cycle, mem_addr driven from req_addr, go to READ.
- **READ**: sample mem_rdata and form the result:
  - byte: lane = addr[1:0], bits 8*lane+7 : 8*lane.
  - halfword: lane = addr[1], bits 16*lane+15 : 16*lane.
  - word: all 32 bits.
  - Bit 7 or bit 15 is replicated unless unsigned.
  - Register rsp_data, set rsp_err=0, go to RESP.
- **RESP**: rsp_valid=1. rsp_data, rsp_err and rsp_pc are held stable until rsp_valid && rsp_ready, then go to IDLE.
- mem_rd_en is asserted for exactly one cycle per non-faulting load and never for a faulting one.
- The block has no internal storage beyond a one-entry request latch and a one-entry response register.

## Timing
- The accept cycle is T (req_valid && req_ready).
- Good load: mem_rd_en at T. rsp_valid first high at T+2.
- Faulting load: rsp_valid first high at T+1.
- Response held for any number of cycles while rsp_ready=0.
- After the rsp handshake at cycle H, req_ready=1 at H+1. Best-case throughput is one good load per 3 cycles.
- rsp_ready asserted before rsp_valid has no effect.
- req_valid outside IDLE is ignored and not latched; the requester must hold the request.
- Reset in any state: next cycle is IDLE with all outputs at their reset values. An in-flight read is discarded and its mem_rdata is never used.
- Reset has priority over a simultaneous request or response handshake.

## Configuration
- Macro: DM_LOAD_ALIGN_CHECK_EN.
- Defined:
  - Halfword with addr[0]=1 → error.
  - Word with addr[1:0]≠0 → error.
- Undefined:
  - No misalignment errors.
  - Halfword ignores addr[0]; word ignores addr[1:0]. This matches the store path's forced alignment.
- The range check and the illegal-type check are always present.

## Test plan
- Memory word index 4 (addr 0x10) = 0x8A7B6C5D. Signed byte load at 0x13 → rsp_data 0xFFFFFF8A, rsp_err 0, rsp_valid at T+2, exactly one mem_rd_en with mem_addr 4.
- Same word, unsigned byte at 0x11 → 0x0000006C. Signed half at 0x12 → 0xFFFF8A7B. Unsigned half at 0x10 → 0x00006C5D. Word at 0x10 → 0x8A7B6C5D.
- Word load at 0x11:
  - With DM_LOAD_ALIGN_CHECK_EN → rsp_err 1, rsp_data 0, rsp_valid at T+1, no mem_rd_en.
  - Without → 0x8A7B6C5D.
- Load at 0x00004000 or with req_type 00 → rsp_err 1, no mem_rd_en. rsp_pc equals the req_pc given (e.g. 0x00003040).
- rsp_ready held low 5 cycles → rsp_valid/rsp_data/rsp_pc stable and req_ready 0 throughout. After the handshake, a second request is accepted on the next cycle.
- Reset asserted in READ → next cycle IDLE, rsp_valid 0, req_ready 1. No response is ever produced for the aborted load.
